// File: rtl/compound_accumulator.sv
// Consumer of the CompoundType stream. b_in_i packs {mode (1 = write, 0 = read), x[31:0] signed, y}.
// Writes fold x into a signed accumulator. Reads, and writes with y set, emit the accumulator on a valid/ready port.
module compound_accumulator #(
  parameter bit SATURATE  = 1'b0,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [33:0]          b_in_i,
  input  logic                 b_in_sync_i,
  output logic                 b_in_notify_o,
  output logic [31:0]          res_out_o,
  input  logic                 res_out_sync_i,
  output logic                 res_out_notify_o,
  output logic [31:0]          acc_status_o,
  output logic [CNT_WIDTH-1:0] txn_count_o
);

  typedef enum logic {
    S_RECV = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [31:0]          acc_q, acc_d;
  logic [31:0]          res_q, res_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 b_rdy_q, b_rdy_d;
  logic                 r_vld_q, r_vld_d;

  logic                 in_write;
  logic [31:0]          in_x;
  logic                 in_y;
  logic [32:0]          sum_ext;
  logic                 sum_ovf;
  logic [31:0]          acc_next;

  assign in_write = b_in_i[33];
  assign in_x     = b_in_i[32:1];
  assign in_y     = b_in_i[0];

  // A 33-bit sign-extended sum exposes signed overflow as a mismatch of the top two bits.
  always_comb begin
    sum_ext  = {acc_q[31], acc_q} + {in_x[31], in_x};
    sum_ovf  = sum_ext[32] ^ sum_ext[31];
    acc_next = sum_ext[31:0];
    if (SATURATE && sum_ovf) begin
      acc_next = sum_ext[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    b_rdy_d = b_rdy_q;
    r_vld_d = r_vld_q;
    unique case (state_q)
      S_RECV: begin
        if (b_in_sync_i) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
          if (in_write) begin
            acc_d = acc_next;
            if (in_y) begin
              res_d   = acc_next;
              state_d = S_SEND;
              b_rdy_d = 1'b0;
              r_vld_d = 1'b1;
            end
          end else begin
            res_d   = acc_q;
            state_d = S_SEND;
            b_rdy_d = 1'b0;
            r_vld_d = 1'b1;
          end
        end
      end
      S_SEND: begin
        // res_q is left untouched so the last result stays visible after the handoff.
        if (res_out_sync_i) begin
          state_d = S_RECV;
          b_rdy_d = 1'b1;
          r_vld_d = 1'b0;
        end
      end
      default: begin
        state_d = S_RECV;
        b_rdy_d = 1'b1;
        r_vld_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_RECV;
      acc_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      b_rdy_q <= 1'b1;
      r_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      b_rdy_q <= b_rdy_d;
      r_vld_q <= r_vld_d;
    end
  end

  assign b_in_notify_o    = b_rdy_q;
  assign res_out_notify_o = r_vld_q;
  assign res_out_o        = res_q;
  assign acc_status_o     = acc_q;
  assign txn_count_o      = cnt_q;

endmodule

// File: tb/tb_compound_accumulator.sv
// Two instances (wrapping and saturating) share one stimulus stream.
// Expected results are queued at acceptance, and a monitor pops them on each result handoff.
module tb_compound_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic [33:0] b_in;
  logic        b_in_sync;
  logic        res_out_sync;

  logic        b_nt0, r_nt0, b_nt1, r_nt1;
  logic [31:0] res0, res1, acc0, acc1;
  logic [15:0] cnt0, cnt1;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_acc0, m_acc1;
  logic [15:0] m_cnt;
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];

  always #5 clk = ~clk;

  compound_accumulator #(.SATURATE(1'b0), .CNT_WIDTH(16)) u_wrap (
    .clk_i(clk), .rst_i(rst), .b_in_i(b_in), .b_in_sync_i(b_in_sync),
    .b_in_notify_o(b_nt0), .res_out_o(res0), .res_out_sync_i(res_out_sync),
    .res_out_notify_o(r_nt0), .acc_status_o(acc0), .txn_count_o(cnt0)
  );

  compound_accumulator #(.SATURATE(1'b1), .CNT_WIDTH(16)) u_sat (
    .clk_i(clk), .rst_i(rst), .b_in_i(b_in), .b_in_sync_i(b_in_sync),
    .b_in_notify_o(b_nt1), .res_out_o(res1), .res_out_sync_i(res_out_sync),
    .res_out_notify_o(r_nt1), .acc_status_o(acc1), .txn_count_o(cnt1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] x);
    longint s;
    s = longint'($signed(a)) + longint'($signed(x));
    if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
    return s[31:0];
  endfunction

  // Monitor: a result handoff happens at the next posedge whenever valid and ready are both high.
  always @(negedge clk) begin
    if (!rst && r_nt0 && res_out_sync) begin
      if (exp_q0.size() == 0) check("res_unexpected_wrap", 64'(r_nt0), 64'd0);
      else check("res_out_wrap_pop", 64'(res0), 64'(exp_q0.pop_front()));
    end
    if (!rst && r_nt1 && res_out_sync) begin
      if (exp_q1.size() == 0) check("res_unexpected_sat", 64'(r_nt1), 64'd0);
      else check("res_out_sat_pop", 64'(res1), 64'(exp_q1.pop_front()));
    end
  end

  task automatic model_reset();
    m_acc0 = '0;
    m_acc1 = '0;
    m_cnt  = '0;
    exp_q0.delete();
    exp_q1.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; b_in_sync = 1'b0; res_out_sync = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check("rst_b_in_notify", 64'(b_nt0), 64'd1);
    check("rst_res_notify", 64'(r_nt0), 64'd0);
    check("rst_res_out", 64'(res0), 64'd0);
    check("rst_acc_status", 64'(acc0), 64'd0);
    check("rst_txn_count", 64'(cnt0), 64'd0);
    check("rst_acc_status_sat", 64'(acc1), 64'd0);
  endtask

  // Called just after a negedge; returns just after a negedge.
  task automatic do_rec(input bit wr, input logic [31:0] x, input bit y, input int stall);
    bit emit;
    logic [31:0] r0, r1;
    b_in = {wr, x, y};
    b_in_sync = 1'b1;
    check("b_in_notify_before", 64'(b_nt0), 64'd1);
    emit = !wr || y;
    if (wr) begin
      m_acc0 = m_acc0 + x;
      m_acc1 = sat_add(m_acc1, x);
    end
    m_cnt = m_cnt + 16'd1;
    r0 = m_acc0;
    r1 = m_acc1;
    if (emit) begin
      exp_q0.push_back(r0);
      exp_q1.push_back(r1);
    end
    @(posedge clk); #1;
    if (emit && stall > 0) begin
      b_in = {1'b1, 32'h1111_1111, 1'b1};
      b_in_sync = 1'b1;
      res_out_sync = 1'b0;
    end else begin
      b_in_sync = 1'b0;
      res_out_sync = emit;
    end
    @(negedge clk);
    check("acc_status_wrap", 64'(acc0), 64'(m_acc0));
    check("acc_status_sat", 64'(acc1), 64'(m_acc1));
    check("txn_count", 64'(cnt0), 64'(m_cnt));
    check("txn_count_sat", 64'(cnt1), 64'(m_cnt));
    check("res_notify_after_accept", 64'(r_nt0), 64'(emit));
    check("b_in_notify_after_accept", 64'(b_nt0), 64'(!emit));
    if (emit) begin
      check("res_out_wrap", 64'(res0), 64'(r0));
      check("res_out_sat", 64'(res1), 64'(r1));
      for (int i = 0; i < stall; i++) begin
        @(posedge clk); #1;
        if (i == stall - 1) begin
          b_in_sync = 1'b0;
          res_out_sync = 1'b1;
        end
        @(negedge clk);
        check("stall_res_notify", 64'(r_nt0), 64'd1);
        check("stall_b_in_blocked", 64'(b_nt0), 64'd0);
        check("stall_txn_count", 64'(cnt0), 64'(m_cnt));
        check("stall_acc", 64'(acc0), 64'(m_acc0));
        check("stall_res_stable", 64'(res0), 64'(r0));
      end
      @(posedge clk); #1;
      res_out_sync = 1'b0;
      @(negedge clk);
      check("b_in_notify_after_send", 64'(b_nt0), 64'd1);
      check("res_notify_after_send", 64'(r_nt0), 64'd0);
      check("res_out_held", 64'(res0), 64'(r0));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; b_in = '0; b_in_sync = 1'b0; res_out_sync = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    do_rec(1'b1, 32'd5, 1'b0, 0);
    do_rec(1'b1, 32'hFFFF_FFFD, 1'b0, 0);
    check("acc_after_two_writes", 64'(acc0), 64'd2);
    check("cnt_after_two_writes", 64'(cnt0), 64'd2);
    do_rec(1'b1, 32'd10, 1'b1, 3);
    check("res_after_stall", 64'(res0), 64'd12);
    do_rec(1'b0, 32'd99, 1'b1, 0);
    check("read_res", 64'(res0), 64'd12);
    check("read_acc_unchanged", 64'(acc0), 64'd12);
    check("read_cnt", 64'(cnt0), 64'd4);

    do_reset();
    do_rec(1'b1, 32'h7FFF_FFF0, 1'b0, 0);
    do_rec(1'b1, 32'h0000_0020, 1'b1, 1);
    check("ovf_wrap_res", 64'(res0), 64'h8000_0010);
    check("ovf_sat_res", 64'(res1), 64'h7FFF_FFFF);
    do_rec(1'b1, 32'h8000_0000, 1'b0, 0);
    do_rec(1'b1, 32'h8000_0000, 1'b1, 0);
    check("neg_sat_res", 64'(res1), 64'h8000_0000);

    // Reset while a result is pending drops it.
    b_in = {1'b1, 32'd7, 1'b1}; b_in_sync = 1'b1;
    @(posedge clk); #1;
    b_in_sync = 1'b0;
    @(negedge clk);
    check("pre_rst_res_notify", 64'(r_nt0), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check("rst_in_send_res_notify", 64'(r_nt0), 64'd0);
    check("rst_in_send_b_in_notify", 64'(b_nt0), 64'd1);
    check("rst_in_send_acc", 64'(acc0), 64'd0);
    check("rst_in_send_cnt", 64'(cnt0), 64'd0);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] x;
      x = ($urandom_range(0, 1) == 0) ? 32'($signed($urandom_range(0, 200)) - 100) : $urandom;
      do_rec($urandom_range(0, 2) != 0, x, $urandom_range(0, 3) == 0, $urandom_range(0, 3));
    end

    do_reset();
    for (int n = 0; n < 65535; n++) begin
      logic [31:0] x;
      x = $urandom;
      b_in = {1'b1, x, 1'b0};
      b_in_sync = 1'b1;
      m_acc0 = m_acc0 + x;
      m_acc1 = sat_add(m_acc1, x);
      m_cnt = m_cnt + 16'd1;
      @(posedge clk); #1;
    end
    b_in_sync = 1'b0;
    @(negedge clk);
    check("cnt_all_ones", 64'(cnt0), 64'hFFFF);
    check("long_acc_wrap", 64'(acc0), 64'(m_acc0));
    check("long_acc_sat", 64'(acc1), 64'(m_acc1));
    do_rec(1'b1, 32'd1, 1'b0, 0);
    check("cnt_wrap_to_zero", 64'(cnt0), 64'd0);

    check("queues_drained", 64'(exp_q0.size() + exp_q1.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
